qspi_master: RTL and testbench
==============================

// Module: qspi_master
// PURPOSE
//  Quad-SPI initiator: drives QSS/QCK and a 4-bit bidirectional QD bus toward a quad-SPI responder (e.g. the Murax
//  QSPI slave, for on-board loopback, or an external quad device). A byte-wide command stream in; read bytes out.
//  Sits between a bus peripheral/controller and the top level, where per-bit QD tristate is resolved by SB_IO cells.
// PARAMETERS
//  CLK_DIV     2  io_mainClk cycles per QCK half-period (>=1)
//  TURN_CYCLES 2  dummy QCK cycles inserted on a write->read direction change within one select (0..15)
// PORTS
//  io_mainClk             in   1  system clock; all logic on rising edge
//  io_reset               in   1  synchronous, active-high reset
//  io_cmd_valid           in   1  command byte offered
//  io_cmd_ready           out  1  command byte accepted this cycle when valid&ready
//  io_cmd_write           in   1  1 = drive io_cmd_data on QD; 0 = read one byte from QD (data ignored)
//  io_cmd_data            in   8  byte to transmit
//  io_cmd_last            in   1  deselect (QSS high) after this byte
//  io_rsp_valid           out  1  one-cycle pulse: io_rsp_data holds a read byte; no backpressure
//  io_rsp_data            out  8  received byte
//  io_busy                out  1  high while QSS is low or deselect timing runs
//  io_qspi_qss            out  1  chip select, active low
//  io_qspi_qck            out  1  quad clock, idles low (mode 0)
//  io_qspi_qd_read        in   4  QD pin input
//  io_qspi_qd_write       out  4  QD pin output value
//  io_qspi_qd_writeEnable out  4  per-bit output enable (all four bits always equal)
// BEHAVIOUR
//  Reset: qss=1, qck=0, qd_write=0, qd_writeEnable=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=0; state IDLE.
//  Reset mid-transaction: abort; next cycle outputs at reset values, no rsp pulse, partial byte discarded.
//  tick = divider reaching CLK_DIV-1; divider restarts at 0 on every state entry. All pin outputs registered.
//  cmd_ready = (state==IDLE || state==NEXT) && !io_reset; accept on valid&ready, latch write/data/last.
//  States:
//   IDLE   : qss=1. Accept -> SETUP.
//   SETUP  : qss=0, qck=0; write: OE=1, qd_write=data[7:4]. One half-period -> TURN if read following a write
//            in this select and TURN_CYCLES>0, else SHIFT.
//   TURN   : OE=0; TURN_CYCLES full QCK cycles, nothing sampled -> SHIFT.
//   SHIFT  : 4 ticks per byte, MSB nibble first. Tick1 qck 0->1; tick2 qck 1->0, read: capture qd_read as [7:4],
//            write: qd_write<=data[3:0]; tick3 qck 0->1; tick4 qck 1->0, read: capture [3:0], rsp_valid pulses
//            the cycle after tick4. After tick4: last -> HOLD, else NEXT.
//   NEXT   : qss=0, qck=0, QD held (OE kept for write). Accept -> SETUP-equivalent nibble load then SHIFT after
//            one half-period (turnaround rule as SETUP). Waits indefinitely.
//   HOLD   : OE=0, one half-period, then qss=1 -> DESEL.
//   DESEL  : qss=1 for one half-period (min deselect), then IDLE. busy=0 only in IDLE.
//  Byte time CLK_DIV*4 cycles; first QCK rise 2*CLK_DIV cycles after accept.
//  Read-after-read or write-after-read: no turnaround. Read never drives OE; write drives OE from SETUP to HOLD.
//  cmd_valid ignored outside IDLE/NEXT; cmd fields must be stable only in the accept cycle.
// STRUCTURE
//  qspi_defs.vh: state localparams, NIBBLE_HI/LO order constants, shared with the responder bench.
//  Sub-module qspi_clk_div: half-period counter with restart input and tick output. FSM + shifter in this file.
// TESTING
//  1 Reset: hold io_reset 3 cycles -> qss=1, qck=0, OE=0, cmd_ready=0; release -> cmd_ready=1 next cycle.
//  2 Write 0xA5 last=1, CLK_DIV=2 -> qss low, QD=0xA at rise 1, 0x5 at rise 2, 2 QCK pulses, qss high after HOLD.
//  3 Write 0x0B last=0 then read last=1, responder drives 0x3C -> 2 dummy QCK cycles with OE=0, rsp_data=0x3C pulse.
//  4 Three back-to-back reads with cmd_valid held high -> qss stays low across bytes, 3 rsp pulses, no turnaround.
//  5 io_reset asserted mid-SHIFT (after tick2) -> next cycle qss=1, qck=0, OE=0, no rsp_valid.
//  6 cmd_valid dropped in NEXT for 50 cycles -> qss stays 0, qck stays 0, QD stable; resumes on next valid.

Source files
------------

// File: rtl/qspi_master_pkg.sv
// Shared definitions for the quad-SPI initiator: FSM state encoding and nibble-order helpers.
package qspi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_TURN  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_NEXT  = 3'd4,
        ST_HOLD  = 3'd5,
        ST_DESEL = 3'd6
    } qspi_state_e;

    localparam logic NIBBLE_HI = 1'b1;
    localparam logic NIBBLE_LO = 1'b0;

    function automatic logic [3:0] nibble_of(input logic [7:0] b, input logic hi);
        return hi ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/qspi_master_clk_div.sv
// Half-period counter: tick_o marks the last system cycle of each QCK half-period.
module qspi_master_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic restart_i,
    output logic tick_o
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/qspi_master.sv
// Quad-SPI initiator: byte command stream in, mode-0 QSS/QCK/QD sequencing out, read bytes back.
// Handshake: a command is taken on any cycle where io_cmd_valid && io_cmd_ready; io_rsp_valid is a one-cycle pulse.
module qspi_master
    import qspi_master_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int TURN_CYCLES = 2
) (
    input  logic       io_mainClk,
    input  logic       io_reset,
    input  logic       io_cmd_valid,
    output logic       io_cmd_ready,
    input  logic       io_cmd_write,
    input  logic [7:0] io_cmd_data,
    input  logic       io_cmd_last,
    output logic       io_rsp_valid,
    output logic [7:0] io_rsp_data,
    output logic       io_busy,
    output logic       io_qspi_qss,
    output logic       io_qspi_qck,
    input  logic [3:0] io_qspi_qd_read,
    output logic [3:0] io_qspi_qd_write,
    output logic [3:0] io_qspi_qd_writeEnable,
    output logic [2:0] io_dbg_state
);

    localparam bit         HAS_TURN  = (TURN_CYCLES > 0);
    localparam logic [4:0] TURN_LAST = 5'(2 * TURN_CYCLES - 1);

    qspi_state_e state_q;
    logic       wr_q, last_q, prev_wr_q;
    logic [7:0] data_q;
    logic [3:0] rx_hi_q;
    logic [1:0] phase_q;
    logic [4:0] turn_cnt_q;
    logic       qss_q, qck_q, oe_q;
    logic [3:0] qd_q;
    logic       rsp_valid_q;
    logic [7:0] rsp_data_q;

    logic tick, waiting, accept, need_turn;

    assign waiting   = (state_q == ST_IDLE) || (state_q == ST_NEXT);
    assign accept    = io_cmd_valid && io_cmd_ready;
    // Turnaround only when the bus direction flips from driven to sampled inside one select.
    assign need_turn = HAS_TURN && prev_wr_q && !wr_q;

    qspi_master_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk_i     (io_mainClk),
        .rst_i     (io_reset),
        .restart_i (waiting),
        .tick_o    (tick)
    );

    always_ff @(posedge io_mainClk) begin
        if (io_reset) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            last_q      <= 1'b0;
            prev_wr_q   <= 1'b0;
            data_q      <= '0;
            rx_hi_q     <= '0;
            phase_q     <= '0;
            turn_cnt_q  <= '0;
            qss_q       <= 1'b1;
            qck_q       <= 1'b0;
            oe_q        <= 1'b0;
            qd_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_NEXT: begin
                    if (accept) begin
                        wr_q    <= io_cmd_write;
                        data_q  <= io_cmd_data;
                        last_q  <= io_cmd_last;
                        qss_q   <= 1'b0;
                        qck_q   <= 1'b0;
                        oe_q    <= io_cmd_write;
                        if (io_cmd_write) qd_q <= nibble_of(io_cmd_data, NIBBLE_HI);
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        phase_q    <= '0;
                        turn_cnt_q <= '0;
                        state_q    <= need_turn ? ST_TURN : ST_SHIFT;
                    end
                end
                ST_TURN: begin
                    if (tick) begin
                        qck_q <= ~qck_q;
                        if (turn_cnt_q == TURN_LAST) state_q <= ST_SHIFT;
                        else                         turn_cnt_q <= turn_cnt_q + 5'd1;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        phase_q <= phase_q + 2'd1;
                        case (phase_q)
                            2'd0: qck_q <= 1'b1;
                            2'd1: begin
                                qck_q <= 1'b0;
                                if (wr_q) qd_q    <= nibble_of(data_q, NIBBLE_LO);
                                else      rx_hi_q <= io_qspi_qd_read;
                            end
                            2'd2: qck_q <= 1'b1;
                            default: begin
                                qck_q     <= 1'b0;
                                prev_wr_q <= wr_q;
                                if (!wr_q) begin
                                    rsp_valid_q <= 1'b1;
                                    rsp_data_q  <= {rx_hi_q, io_qspi_qd_read};
                                end
                                if (last_q) begin
                                    oe_q    <= 1'b0;
                                    state_q <= ST_HOLD;
                                end else begin
                                    state_q <= ST_NEXT;
                                end
                            end
                        endcase
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        qss_q     <= 1'b1;
                        prev_wr_q <= 1'b0;
                        state_q   <= ST_DESEL;
                    end
                end
                ST_DESEL: begin
                    if (tick) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign io_cmd_ready           = waiting && !io_reset;
    assign io_busy                = (state_q != ST_IDLE);
    assign io_rsp_valid           = rsp_valid_q;
    assign io_rsp_data            = rsp_data_q;
    assign io_qspi_qss            = qss_q;
    assign io_qspi_qck            = qck_q;
    assign io_qspi_qd_write       = qd_q;
    assign io_qspi_qd_writeEnable = {4{oe_q}};
    assign io_dbg_state           = state_q;

endmodule

// File: tb/tb_qspi_master.sv
// Self-checking bench for qspi_master with a behavioural mode-0 quad responder and byte scoreboards.
module tb_qspi_master;
    import qspi_master_pkg::*;

    localparam int CLK_DIV     = 2;
    localparam int TURN_CYCLES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       cmd_last = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       qss, qck;
    logic [3:0] qd_r = '0;
    logic [3:0] qd_w, oe;
    logic [2:0] dbg_state;

    always #5 clk = ~clk;

    qspi_master #(.CLK_DIV(CLK_DIV), .TURN_CYCLES(TURN_CYCLES)) dut (
        .io_mainClk             (clk),
        .io_reset               (rst),
        .io_cmd_valid           (cmd_valid),
        .io_cmd_ready           (cmd_ready),
        .io_cmd_write           (cmd_write),
        .io_cmd_data            (cmd_data),
        .io_cmd_last            (cmd_last),
        .io_rsp_valid           (rsp_valid),
        .io_rsp_data            (rsp_data),
        .io_busy                (busy),
        .io_qspi_qss            (qss),
        .io_qspi_qck            (qck),
        .io_qspi_qd_read        (qd_r),
        .io_qspi_qd_write       (qd_w),
        .io_qspi_qd_writeEnable (oe),
        .io_dbg_state           (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] wexp_q[$];
    logic [7:0] resp_byte_q[$];
    int         resp_skip_q[$];

    int rise_cnt = 0, rise_oe0_cnt = 0, rsp_cnt = 0, qss_rise_cnt = 0;
    logic prev_qck = 1'b0, prev_qss = 1'b1;
    int   wnib_n = 0;
    logic [7:0] wbyte = '0;
    logic r_active = 1'b0;
    logic [7:0] r_byte = '0;
    int   r_need = 0, r_rises = 0;

    // Responder drives the high nibble before the first real rise and the low nibble after the following fall.
    always @(negedge clk) begin
        if (rst) begin
            r_active = 1'b0;
            resp_byte_q.delete();
            resp_skip_q.delete();
            wnib_n   = 0;
            prev_qck = 1'b0;
            prev_qss = 1'b1;
        end else begin
            if (qck && !prev_qck) begin
                rise_cnt++;
                if (oe == 4'h0) rise_oe0_cnt++;
                if (r_active) r_rises++;
                if (oe == 4'hF) begin
                    wbyte = {wbyte[3:0], qd_w};
                    wnib_n++;
                    if (wnib_n == 2) begin
                        logic [7:0] e;
                        wnib_n = 0;
                        n_checks++;
                        if (wexp_q.size() == 0) begin
                            n_errors++;
                            $display("FAIL wr_byte unexpected got %h", wbyte);
                        end else begin
                            e = wexp_q.pop_front();
                            if (wbyte !== e) begin
                                n_errors++;
                                $display("FAIL wr_byte got %h exp %h", wbyte, e);
                            end
                        end
                    end
                end
            end
            if (!qck && prev_qck && r_active) begin
                if (r_rises == r_need)          qd_r = r_byte[3:0];
                else if (r_rises == r_need + 1) r_active = 1'b0;
            end
            if (!r_active && resp_byte_q.size() > 0) begin
                r_byte   = resp_byte_q.pop_front();
                r_need   = resp_skip_q.pop_front() + 1;
                r_rises  = 0;
                r_active = 1'b1;
                qd_r     = r_byte[7:4];
            end
            if (qss && !prev_qss) qss_rise_cnt++;
            if (rsp_valid) begin
                logic [7:0] e;
                rsp_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rsp_data unexpected got %h", rsp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_data !== e) begin
                        n_errors++;
                        $display("FAIL rsp_data got %h exp %h", rsp_data, e);
                    end
                end
            end
            prev_qck = qck;
            prev_qss = qss;
        end
    end

    task automatic send_cmd(input logic wr, input logic [7:0] d, input logic last);
        int waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_data  = d;
        cmd_last  = last;
        while (!cmd_ready && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL cmd_accept timeout got ready=%b exp 1", cmd_ready);
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic idle_cmd();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (busy) begin
            n_errors++;
            $display("FAIL idle_timeout got busy=%b exp 0", busy);
        end
    endtask

    task automatic issue_write(input logic [7:0] d, input logic last);
        wexp_q.push_back(d);
        send_cmd(1'b1, d, last);
    endtask

    task automatic issue_read(input logic [7:0] d, input int skip, input logic last);
        exp_q.push_back(d);
        resp_byte_q.push_back(d);
        resp_skip_q.push_back(skip);
        send_cmd(1'b0, 8'h00, last);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (qss !== 1'b1 || qck !== 1'b0 || oe !== 4'h0 || qd_w !== 4'h0) begin
            n_errors++;
            $display("FAIL reset_pins got qss=%b qck=%b oe=%h qd=%h exp 1 0 0 0", qss, qck, oe, qd_w);
        end
        n_checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl got ready=%b busy=%b exp 0 0", cmd_ready, busy);
        end
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_rsp got valid=%b data=%h exp 0 00", rsp_valid, rsp_data);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1 || dbg_state !== 3'(ST_IDLE)) begin
            n_errors++;
            $display("FAIL reset_release got ready=%b state=%0d exp 1 0", cmd_ready, dbg_state);
        end
    endtask

    task automatic test_write_single();
        int br = rise_cnt, bq = qss_rise_cnt;
        issue_write(8'hA5, 1'b1);
        idle_cmd();
        wait_idle();
        n_checks++;
        if (rise_cnt - br != 2) begin
            n_errors++;
            $display("FAIL wr_single_rises got %0d exp 2", rise_cnt - br);
        end
        n_checks++;
        if (qss !== 1'b1 || qss_rise_cnt - bq != 1 || oe !== 4'h0) begin
            n_errors++;
            $display("FAIL wr_single_desel got qss=%b rises=%0d oe=%h exp 1 1 0", qss, qss_rise_cnt - bq, oe);
        end
    endtask

    task automatic test_write_then_read();
        int br = rise_cnt, bo = rise_oe0_cnt, bp = rsp_cnt;
        issue_write(8'h0B, 1'b0);
        issue_read(8'h3C, 2 + TURN_CYCLES, 1'b1);
        idle_cmd();
        wait_idle();
        n_checks++;
        if (rise_cnt - br != 6 || rise_oe0_cnt - bo != 4) begin
            n_errors++;
            $display("FAIL turn_rises got total=%0d oe0=%0d exp 6 4", rise_cnt - br, rise_oe0_cnt - bo);
        end
        n_checks++;
        if (rsp_cnt - bp != 1 || exp_q.size() != 0 || wexp_q.size() != 0) begin
            n_errors++;
            $display("FAIL turn_rsp got pulses=%0d pend=%0d exp 1 0", rsp_cnt - bp, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int br = rise_cnt, bo = rise_oe0_cnt, bp = rsp_cnt, bq = qss_rise_cnt;
        logic [7:0] vals [3];
        for (int i = 0; i < 3; i++) vals[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3; i++) issue_read(vals[i], 0, (i == 2));
        idle_cmd();
        wait_idle();
        n_checks++;
        if (rise_cnt - br != 6 || rise_oe0_cnt - bo != 6) begin
            n_errors++;
            $display("FAIL b2b_rises got total=%0d oe0=%0d exp 6 6", rise_cnt - br, rise_oe0_cnt - bo);
        end
        n_checks++;
        if (rsp_cnt - bp != 3 || qss_rise_cnt - bq != 1) begin
            n_errors++;
            $display("FAIL b2b_select got pulses=%0d desel=%0d exp 3 1", rsp_cnt - bp, qss_rise_cnt - bq);
        end
    endtask

    task automatic test_reset_mid_shift();
        int br = rise_cnt, bp = rsp_cnt, waited = 0;
        resp_byte_q.push_back(8'h96);
        resp_skip_q.push_back(0);
        send_cmd(1'b0, 8'h00, 1'b1);
        idle_cmd();
        #1;
        while (!(rise_cnt > br && !qck) && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_checks++;
        if (!(rise_cnt > br && !qck)) begin
            n_errors++;
            $display("FAIL midreset_wait got rises=%0d exp >=1", rise_cnt - br);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (qss !== 1'b1 || qck !== 1'b0 || oe !== 4'h0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_pins got qss=%b qck=%b oe=%h rv=%b busy=%b exp 1 0 0 0 0",
                     qss, qck, oe, rsp_valid, busy);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (rsp_cnt != bp || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_norsp got pulses=%0d busy=%b exp 0 0", rsp_cnt - bp, busy);
        end
    endtask

    task automatic test_next_stall();
        int br = rise_cnt, bq = qss_rise_cnt, waited = 0, bad = 0;
        logic [3:0] qd0;
        issue_write(8'h3E, 1'b0);
        idle_cmd();
        while (dbg_state !== 3'(ST_NEXT) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        qd0 = qd_w;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (qss !== 1'b0 || qck !== 1'b0 || qd_w !== qd0 || oe !== 4'hF) bad++;
        end
        n_checks++;
        if (bad != 0 || dbg_state !== 3'(ST_NEXT) || qd0 !== 4'hE) begin
            n_errors++;
            $display("FAIL next_stall got bad=%0d state=%0d qd=%h exp 0 4 e", bad, dbg_state, qd0);
        end
        issue_write(8'hC1, 1'b1);
        idle_cmd();
        wait_idle();
        n_checks++;
        if (rise_cnt - br != 4 || qss_rise_cnt - bq != 1 || wexp_q.size() != 0) begin
            n_errors++;
            $display("FAIL next_resume got rises=%0d desel=%0d pend=%0d exp 4 1 0",
                     rise_cnt - br, qss_rise_cnt - bq, wexp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_single();
        test_write_then_read();
        test_back_to_back();
        test_reset_mid_shift();
        test_next_stall();
        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
